raytracer_dda: RTL and testbench

Parametrised next-generation grid raytracer. It marches a ray from a fixed-point start position along a caller-supplied signed direction vector, one step per iteration, reading the map grid each step. It stops on the first non-empty cell, after a step limit, or (optionally) when the ray leaves the map. It sits between the column renderer and the grid memory, and returns hit cell, wall orientation, cell contents and step count for wall-height and texture selection.

---
 rtl/raytracer_pkg.sv | 26 ++
 rtl/raytracer_dda_fsm.sv | 56 +++++
 rtl/raytracer_dda.sv | 143 ++++++++++++++
 tb/tb_raytracer_dda.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/raytracer_pkg.sv
// Shared definitions for the raytracer_dda grid ray marcher: FSM state encoding,
// wall-orientation codes and fixed-point width helpers.
package raytracer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_CHECK = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic DIR_HORIZONTAL = 1'b0;
  localparam logic DIR_VERTICAL   = 1'b1;

  function automatic int pos_w(input int grid_bits, input int frac_bits);
    return grid_bits + frac_bits;
  endfunction

  // Common width holding |dir| for either axis (dir is one bit wider than pos).
  function automatic int mag_w(input int gx_bits, input int gy_bits, input int frac_bits);
    return ((gx_bits > gy_bits) ? gx_bits : gy_bits) + frac_bits + 1;
  endfunction

endpackage

// File: rtl/raytracer_dda_fsm.sv
// Control sequencer for raytracer_dda: state register, grid-read wait insertion
// and the busy/done strobes.
module raytracer_dda_fsm
  import raytracer_pkg::*;
#(
  parameter int MEM_LATENCY = 0
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_start,
  input  logic   i_hit,
  input  logic   i_max,
  input  logic   i_oob,
  output state_t o_state,
  output logic   o_busy,
  output logic   o_done
);

  // After every position update the grid read either needs a wait cycle or not.
  localparam state_t AFTER_MOVE = (MEM_LATENCY != 0) ? ST_FETCH : ST_CHECK;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b1;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = ST_LOAD;
      end
      ST_LOAD:  w_next = AFTER_MOVE;
      ST_FETCH: w_next = ST_CHECK;
      ST_CHECK: w_next = (i_hit || i_max) ? ST_DONE : ST_STEP;
      ST_STEP:  w_next = i_oob ? ST_DONE : AFTER_MOVE;
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/raytracer_dda.sv
// Fixed-point grid ray marcher: steps a ray through the map until a non-empty cell,
// the step limit, or (with RAYTRACER_OOB_CHECK_EN defined) leaving the map.
module raytracer_dda
  import raytracer_pkg::*;
#(
  parameter int GX_BITS     = 6,
  parameter int GY_BITS     = 5,
  parameter int FRAC_BITS   = 8,
  parameter int CELL_BITS   = 3,
  parameter int MAX_STEPS   = 255,
  parameter int STEP_BITS   = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic                                start,
  input  logic        [GX_BITS+FRAC_BITS-1:0] x,
  input  logic        [GY_BITS+FRAC_BITS-1:0] y,
  input  logic signed [GX_BITS+FRAC_BITS:0]   dir_x,
  input  logic signed [GY_BITS+FRAC_BITS:0]   dir_y,
  output logic                                busy,
  output logic                                done,
  output logic        [GX_BITS-1:0]           grid_x,
  output logic        [GY_BITS-1:0]           grid_y,
  input  logic        [CELL_BITS-1:0]         grid_out,
  output logic        [GX_BITS-1:0]           result_x,
  output logic        [GY_BITS-1:0]           result_y,
  output logic                                result_dir,
  output logic        [CELL_BITS-1:0]         result_cell,
  output logic                                result_hit,
  output logic                                result_oob,
  output logic        [STEP_BITS-1:0]         result_steps
);

  localparam int PXW = pos_w(GX_BITS, FRAC_BITS);
  localparam int PYW = pos_w(GY_BITS, FRAC_BITS);
  localparam int MW  = mag_w(GX_BITS, GY_BITS, FRAC_BITS);
  localparam logic [STEP_BITS-1:0] STEP_LIMIT = STEP_BITS'(MAX_STEPS);

  state_t                 w_state;
  logic [PXW-1:0]         r_pos_x;
  logic [PYW-1:0]         r_pos_y;
  logic [GX_BITS-1:0]     r_prev_cx;
  logic [GY_BITS-1:0]     r_prev_cy;
  logic signed [PXW:0]    r_dir_x;
  logic signed [PYW:0]    r_dir_y;
  logic [STEP_BITS-1:0]   r_steps;
  logic [PXW-1:0]         w_next_x;
  logic [PYW-1:0]         w_next_y;
  logic [PXW:0]           w_mag_x;
  logic [PYW:0]           w_mag_y;
  logic                   w_hit, w_max, w_oob, w_cap;
  logic                   w_dx, w_dy, w_xmaj, w_dir;

  raytracer_dda_fsm #(.MEM_LATENCY(MEM_LATENCY)) u_fsm (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_start (start),
    .i_hit   (w_hit),
    .i_max   (w_max),
    .i_oob   (w_oob),
    .o_state (w_state),
    .o_busy  (busy),
    .o_done  (done)
  );

`ifdef RAYTRACER_OOB_CHECK_EN
  // One extra bit catches both carry (past the far edge) and borrow (below zero).
  logic [PXW:0] w_sum_x;
  logic [PYW:0] w_sum_y;
  assign w_sum_x  = {1'b0, r_pos_x} + $unsigned(r_dir_x);
  assign w_sum_y  = {1'b0, r_pos_y} + $unsigned(r_dir_y);
  assign w_next_x = w_sum_x[PXW-1:0];
  assign w_next_y = w_sum_y[PYW-1:0];
  assign w_oob    = w_sum_x[PXW] | w_sum_y[PYW];
`else
  assign w_next_x = r_pos_x + r_dir_x[PXW-1:0];
  assign w_next_y = r_pos_y + r_dir_y[PYW-1:0];
  assign w_oob    = 1'b0;
`endif

  assign grid_x = r_pos_x[PXW-1:FRAC_BITS];
  assign grid_y = r_pos_y[PYW-1:FRAC_BITS];
  assign w_hit  = (grid_out != '0);
  assign w_max  = (r_steps == STEP_LIMIT);

  assign w_mag_x = r_dir_x[PXW] ? $unsigned(-r_dir_x) : $unsigned(r_dir_x);
  assign w_mag_y = r_dir_y[PYW] ? $unsigned(-r_dir_y) : $unsigned(r_dir_y);
  assign w_xmaj  = MW'(w_mag_x) > MW'(w_mag_y);
  assign w_dx    = (r_prev_cx != r_pos_x[PXW-1:FRAC_BITS]);
  assign w_dy    = (r_prev_cy != r_pos_y[PYW-1:FRAC_BITS]);
  // Single-axis crossings name the wall directly; otherwise the dominant axis decides.
  assign w_dir   = (w_dx && !w_dy) ? DIR_VERTICAL :
                   (w_dx == w_dy)  ? w_xmaj : DIR_HORIZONTAL;

  assign w_cap = ((w_state == ST_CHECK) && (w_hit || w_max)) ||
                 ((w_state == ST_STEP) && w_oob);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_prev_cx    <= '0;
      r_prev_cy    <= '0;
      r_dir_x      <= '0;
      r_dir_y      <= '0;
      r_steps      <= '0;
      result_x     <= '0;
      result_y     <= '0;
      result_dir   <= 1'b0;
      result_cell  <= '0;
      result_hit   <= 1'b0;
      result_oob   <= 1'b0;
      result_steps <= '0;
    end else begin
      if (w_state == ST_LOAD) begin
        r_pos_x   <= x;
        r_pos_y   <= y;
        r_prev_cx <= x[PXW-1:FRAC_BITS];
        r_prev_cy <= y[PYW-1:FRAC_BITS];
        r_dir_x   <= dir_x;
        r_dir_y   <= dir_y;
        r_steps   <= '0;
      end else if ((w_state == ST_STEP) && !w_oob) begin
        r_prev_cx <= r_pos_x[PXW-1:FRAC_BITS];
        r_prev_cy <= r_pos_y[PYW-1:FRAC_BITS];
        r_pos_x   <= w_next_x;
        r_pos_y   <= w_next_y;
        r_steps   <= r_steps + STEP_BITS'(1);
      end
      if (w_cap) begin
        result_x     <= r_pos_x[PXW-1:FRAC_BITS];
        result_y     <= r_pos_y[PYW-1:FRAC_BITS];
        result_dir   <= w_dir;
        result_cell  <= ((w_state == ST_CHECK) && w_hit) ? grid_out : '0;
        result_hit   <= (w_state == ST_CHECK) && w_hit;
        result_oob   <= (w_state == ST_STEP) && w_oob;
        result_steps <= r_steps;
      end
    end
  end

endmodule

// File: tb/tb_raytracer_dda.sv
// Bench for raytracer_dda: instance A (defaults, zero-latency grid) and instance B
// (MAX_STEPS=4, registered grid read). Honors RAYTRACER_OOB_CHECK_EN.
module tb_raytracer_dda;

  typedef struct {
    int                 id;
    bit                 sel;
    logic [13:0]        x;
    logic [12:0]        y;
    logic signed [14:0] dx;
    logic signed [13:0] dy;
    int                 wx, wy;
    logic [2:0]         wv;
    int ex, ey, edir, ecell, ehit, eoob, esteps, elat;
    int scyc;
  } vec_t;

  logic clk, rst_n, start_a, start_b;
  logic [13:0] x;
  logic [12:0] y;
  logic signed [14:0] dir_x;
  logic signed [13:0] dir_y;
  logic busy_a, done_a, rdir_a, rhit_a, roob_a;
  logic busy_b, done_b, rdir_b, rhit_b, roob_b;
  logic [5:0] gx_a, gx_b, rx_a, rx_b;
  logic [4:0] gy_a, gy_b, ry_a, ry_b;
  logic [2:0] gout_a, gout_b, rcell_a, rcell_b;
  logic [7:0] rsteps_a, rsteps_b;

  logic [2:0] grid [0:31][0:63];
  vec_t q_a[$];
  vec_t q_b[$];
  vec_t tv[8];
  int checks, errors, cyc, ndone_a;

  raytracer_dda #(.MEM_LATENCY(0)) u_dut_a (
    .clock(clk), .resetn(rst_n), .start(start_a), .x(x), .y(y), .dir_x(dir_x), .dir_y(dir_y),
    .busy(busy_a), .done(done_a), .grid_x(gx_a), .grid_y(gy_a), .grid_out(gout_a),
    .result_x(rx_a), .result_y(ry_a), .result_dir(rdir_a), .result_cell(rcell_a),
    .result_hit(rhit_a), .result_oob(roob_a), .result_steps(rsteps_a));

  raytracer_dda #(.MAX_STEPS(4), .MEM_LATENCY(1)) u_dut_b (
    .clock(clk), .resetn(rst_n), .start(start_b), .x(x), .y(y), .dir_x(dir_x), .dir_y(dir_y),
    .busy(busy_b), .done(done_b), .grid_x(gx_b), .grid_y(gy_b), .grid_out(gout_b),
    .result_x(rx_b), .result_y(ry_b), .result_dir(rdir_b), .result_cell(rcell_b),
    .result_hit(rhit_b), .result_oob(roob_b), .result_steps(rsteps_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign gout_a = grid[gy_a][gx_a];
  always @(posedge clk) gout_b <= grid[gy_b][gx_b];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_done(input bit sel);
    vec_t e;
    string p;
    if (sel ? (q_b.size() == 0) : (q_a.size() == 0)) begin
      chk($sformatf("unexpected_done_dut%0d", sel), 1, 0);
      return;
    end
    if (sel) e = q_b.pop_front();
    else     e = q_a.pop_front();
    p = $sformatf("v%0d_", e.id);
    chk({p, "latency"}, cyc - e.scyc, e.elat);
    chk({p, "result_x"},     sel ? int'(rx_b)     : int'(rx_a),     e.ex);
    chk({p, "result_y"},     sel ? int'(ry_b)     : int'(ry_a),     e.ey);
    chk({p, "result_dir"},   sel ? int'(rdir_b)   : int'(rdir_a),   e.edir);
    chk({p, "result_cell"},  sel ? int'(rcell_b)  : int'(rcell_a),  e.ecell);
    chk({p, "result_hit"},   sel ? int'(rhit_b)   : int'(rhit_a),   e.ehit);
    chk({p, "result_oob"},   sel ? int'(roob_b)   : int'(roob_a),   e.eoob);
    chk({p, "result_steps"}, sel ? int'(rsteps_b) : int'(rsteps_a), e.esteps);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      ndone_a++;
      check_done(1'b0);
    end
    if (done_b) check_done(1'b1);
  end

  function automatic vec_t mk(input int id, sel, xi, yi, dxi, dyi, wx, wy, wv,
                              ex, ey, edir, ecell, ehit, eoob, esteps, elat);
    vec_t v;
    v.id = id;        v.sel = sel[0];
    v.x = 14'(xi);    v.y = 13'(yi);
    v.dx = 15'(dxi);  v.dy = 14'(dyi);
    v.wx = wx;        v.wy = wy;       v.wv = 3'(wv);
    v.ex = ex;        v.ey = ey;       v.edir = edir;  v.ecell = ecell;
    v.ehit = ehit;    v.eoob = eoob;   v.esteps = esteps; v.elat = elat;
    v.scyc = 0;
    return v;
  endfunction

  task automatic clear_grid();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++)
        grid[r][c] = 3'd0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (((q_a.size() != 0) || (q_b.size() != 0)) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      chk("done_timeout", 0, 1);
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
  endtask

  task automatic setup(input vec_t v);
    clear_grid();
    if (v.wv != 3'd0) grid[v.wy][v.wx] = v.wv;
    x = v.x; y = v.y; dir_x = v.dx; dir_y = v.dy;
  endtask

  task automatic run_vec(input vec_t v);
    setup(v);
    v.scyc = cyc;
    if (v.sel) begin q_b.push_back(v); start_b = 1'b1; end
    else       begin q_a.push_back(v); start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_idle(2000);
  endtask

  task automatic chk_cleared(input string p);
    chk({p, "busy_a"}, int'(busy_a), 0);
    chk({p, "done_a"}, int'(done_a), 0);
    chk({p, "rx_a"}, int'(rx_a), 0);
    chk({p, "ry_a"}, int'(ry_a), 0);
    chk({p, "rdir_a"}, int'(rdir_a), 0);
    chk({p, "rcell_a"}, int'(rcell_a), 0);
    chk({p, "rhit_a"}, int'(rhit_a), 0);
    chk({p, "roob_a"}, int'(roob_a), 0);
    chk({p, "rsteps_a"}, int'(rsteps_a), 0);
    chk({p, "busy_b"}, int'(busy_b), 0);
    chk({p, "ry_b"}, int'(ry_b), 0);
    chk({p, "rsteps_b"}, int'(rsteps_b), 0);
  endtask

  initial begin
    vec_t v;
    int d0;
    checks = 0; errors = 0; ndone_a = 0;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    x = '0; y = '0; dir_x = '0; dir_y = '0;
    clear_grid();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_cleared("reset_");
    rst_n = 1'b1;
    @(negedge clk);

    //         id sel x      y      dx    dy   wx wy wv  ex ey dir cell hit oob steps lat
    tv[0] = mk(0, 0, 'h180, 'h180, 256,  0,   3, 1, 2,  3, 1, 1,  2,   1,  0,  2,    7);
    tv[1] = mk(1, 1, 'h180, 'h180, 256,  0,   3, 1, 2,  3, 1, 1,  2,   1,  0,  2,    10);
    tv[2] = mk(2, 0, 'h180, 'h180, 0,    256, 1, 1, 5,  1, 1, 0,  5,   1,  0,  0,    3);
    tv[3] = mk(3, 1, 'h180, 'h180, 16,   0,   0, 0, 0,  1, 1, 1,  0,   0,  0,  4,    16);
    tv[4] = mk(4, 0, 'h180, 'h180, 384,  256, 3, 2, 7,  3, 2, 1,  7,   1,  0,  1,    5);
    tv[5] = mk(5, 0, 'h180, 'h180, -256, 256, 0, 2, 3,  0, 2, 0,  3,   1,  0,  1,    5);
`ifdef RAYTRACER_OOB_CHECK_EN
    tv[6] = mk(6, 0, 'h080, 'h180, -256, 0,   0, 0, 0,  0, 1, 1,  0,   0,  1,  0,    4);
    tv[7] = mk(7, 1, 'h080, 'h180, -256, 0,   0, 0, 0,  0, 1, 1,  0,   0,  1,  0,    5);
`else
    tv[6] = mk(6, 0, 'h080, 'h180, -256, 0,   0, 0, 0,  1, 1, 1,  0,   0,  0,  255,  513);
    tv[7] = mk(7, 1, 'h080, 'h180, -256, 0,   0, 0, 0,  60, 1, 1, 0,   0,  0,  4,    16);
`endif
    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Reset pulsed while instance A sits in STEP.
    v = mk(8, 0, 'h180, 'h180, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setup(v);
    d0 = ndone_a;
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy_before_reset", int'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk_cleared("midray_reset_");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", ndone_a - d0, 0);

    // Start pulses while busy must be ignored.
    v = tv[0];
    v.id = 9;
    setup(v);
    d0 = ndone_a;
    v.scyc = cyc;
    q_a.push_back(v);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    chk("single_done_when_restarted", ndone_a - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
